// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data sides
// Define MEM_ARB_PERF_CNT_EN to add grant and contention counters.
module mem_port_arbiter #(
    parameter int width     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_read,
    input  logic [width-1:0]     i_address,
    output logic [width-1:0]     i_rdata,
    output logic                 i_resp,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [width-1:0]     d_address,
    input  logic [width-1:0]     d_wdata,
    input  logic [width/8-1:0]   d_mbe,
    output logic [width-1:0]     d_rdata,
    output logic                 d_resp,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [width-1:0]     mem_address,
    output logic [width-1:0]     mem_wdata,
    output logic [width/8-1:0]   mem_mbe,
    input  logic [width-1:0]     mem_rdata,
    input  logic                 mem_resp
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] i_grant_cnt,
    output logic [CNT_WIDTH-1:0] d_grant_cnt,
    output logic [CNT_WIDTH-1:0] contention_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    state_t             state;
    state_t             state_next;
    logic               last_grant_d;
    logic               cap_write;
    logic [width-1:0]   cap_address;
    logic [width-1:0]   cap_wdata;
    logic [width/8-1:0] cap_mbe;
    logic               i_req;
    logic               d_req;
    logic               grant_i;
    logic               grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Grants are only issued from IDLE; a tie goes to the side that did not win last time.
    always_comb begin
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    grant_i = last_grant_d;
                    grant_d = !last_grant_d;
                end else begin
                    grant_i = i_req;
                    grant_d = d_req;
                end
                if (grant_i) begin
                    state_next = I_BUSY;
                end else if (grant_d) begin
                    state_next = D_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            cap_write    <= 1'b0;
            cap_address  <= '0;
            cap_wdata    <= '0;
            cap_mbe      <= '0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                cap_write    <= 1'b0;
                cap_address  <= i_address;
                cap_wdata    <= '0;
                cap_mbe      <= '1;
                last_grant_d <= 1'b0;
            end else if (grant_d) begin
                // read+write together is illegal upstream; the write wins
                cap_write    <= d_write;
                cap_address  <= d_address;
                cap_wdata    <= d_wdata;
                cap_mbe      <= d_mbe;
                last_grant_d <= 1'b1;
            end
        end
    end

    assign mem_read    = (state != IDLE) && !cap_write;
    assign mem_write   = (state != IDLE) && cap_write;
    assign mem_address = cap_address;
    assign mem_wdata   = cap_wdata;
    assign mem_mbe     = cap_mbe;

    assign i_resp  = (state == I_BUSY) && mem_resp;
    assign d_resp  = (state == D_BUSY) && mem_resp;
    assign i_rdata = i_resp ? mem_rdata : '0;
    assign d_rdata = d_resp ? mem_rdata : '0;

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            i_grant_cnt    <= '0;
            d_grant_cnt    <= '0;
            contention_cnt <= '0;
        end else begin
            if (grant_i) begin
                i_grant_cnt <= i_grant_cnt + 1'b1;
            end
            if (grant_d) begin
                d_grant_cnt <= d_grant_cnt + 1'b1;
            end
            if ((state == IDLE) && i_req && d_req) begin
                contention_cnt <= contention_cnt + 1'b1;
            end
        end
    end
`else
    // Counter width only matters when the counters are built.
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one physical memory port between the instruction-fetch side and the data-access side of the core.
- Upstream, the fetch side uses the level read/resp handshake: it holds a read and address until it gets a one-cycle resp pulse. The data side uses the same handshake with read or write.
- Downstream, it drives a single memory/cache port with the same handshake.
- Contains a 3-state FSM, per-request capture registers and round-robin fairness between the two requesters.

Parameters:
- width, 32, data/address width in bits.
- CNT_WIDTH, 16, width of the optional grant counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_read  input  1  instruction read request; held until i_resp.
- i_address  input  width  instruction address.
- i_rdata  output  width  instruction read data; valid when i_resp=1.
- i_resp  output  1  one-cycle completion pulse to the fetch side.
- d_read  input  1  data read request; held until d_resp.
- d_write  input  1  data write request; held until d_resp.
- d_address  input  width  data address.
- d_wdata  input  width  data write data.
- d_mbe  input  width/8  data byte enables.
- d_rdata  output  width  data read data; valid when d_resp=1.
- d_resp  output  1  one-cycle completion pulse to the data side.
- mem_read  output  1  downstream read strobe.
- mem_write  output  1  downstream write strobe.
- mem_address  output  width  downstream address.
- mem_wdata  output  width  downstream write data.
- mem_mbe  output  width/8  downstream byte enables.
- mem_rdata  input  width  downstream read data.
- mem_resp  input  1  downstream completion pulse.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state<=IDLE, last_grant<=DATA, so the first contended grant goes to the instruction side.
  - All capture registers <=0.
  - Outputs in the following cycle: mem_read=0, mem_write=0, i_resp=0, d_resp=0; mem_address, mem_wdata, mem_mbe, i_rdata, d_rdata = 0.
- FSM states are IDLE, I_BUSY and D_BUSY.
- IDLE transitions:
  - Pending requests are i_req=i_read and d_req=d_read|d_write.
  - Only i_req: go to I_BUSY.
  - Only d_req: go to D_BUSY.
  - Both: grant the side opposite to last_grant.
  - Neither: stay in IDLE.
- Capture at grant (edge leaving IDLE):
  - Addr, op, wdata and mbe are captured into registers.
  - For an I grant: op=read, mbe=all ones, wdata=0.
  - d_read and d_write both high is illegal; it is treated as a write.
  - last_grant<=granted side.
- Busy outputs:
  - In I_BUSY/D_BUSY, mem_read or mem_write=1 per the captured op; mem_address, mem_wdata and mem_mbe come from the capture registers only.
  - Upstream inputs changing mid-transaction have no effect.
  - Latency: the request is seen in cycle N and the mem strobe asserts in cycle N+1.
- Completion (mem_resp=1 in a BUSY state):
  - Combinationally, the owner's resp=1 and its rdata=mem_rdata in that same cycle.
  - The non-owner's resp=0 and rdata=0.
  - Next state is IDLE. This gives one mandatory turnaround cycle, so back-to-back grants are spaced at least by mem latency + 1.
- In IDLE, mem_resp is ignored: no upstream resp is produced.
- Strobes deassert in the IDLE cycle after completion.
- Request withdrawn mid-transaction: the transaction still completes and the resp pulse is still issued.
- A request still asserted in the cycle after its resp is treated as a new request. This is normal for continuous fetch.
- Fairness:
  - With both sides continuously requesting, grants strictly alternate I, D, I, D.
  - No requester waits more than one foreign transaction.
- Reset mid-transaction: state goes to IDLE, the strobe drops next cycle, the in-flight response is discarded, and a later stray mem_resp is ignored.
- i_resp and d_resp are never 1 in the same cycle. mem_read and mem_write are never 1 in the same cycle.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, add outputs i_grant_cnt [CNT_WIDTH], d_grant_cnt [CNT_WIDTH] and contention_cnt [CNT_WIDTH].
  - Each grant counter increments on every grant edge to its side.
  - contention_cnt increments on each IDLE cycle with both i_req and d_req high.
  - All three reset to 0 on rst and wrap modulo 2^CNT_WIDTH.
- When not defined, these ports and registers do not exist, and arbitration behaviour is identical.

Test Plan:
- Single fetch: i_read=1, i_address=0x0000_0060; memory responds after 3 cycles with mem_rdata=0x0000_0013.
  - Expect mem_read=1 and mem_address=0x60 from cycle 1.
  - Expect i_resp=1 and i_rdata=0x13 for exactly one cycle; d_resp stays 0 throughout.
- Data write: d_write=1, d_address=0x100, d_wdata=0xDEADBEEF, d_mbe=4'b0011.
  - Expect mem_write=1 with the same values held while busy, even if d_wdata is changed to 0 after the grant.
  - Expect d_resp to pulse once.
- Contention from reset: i_read and d_read are both held high for 4 transactions.
  - Expect grant order I, D, I, D.
  - Expect each mem strobe preceded by exactly one IDLE cycle.
- Stray response: mem_resp=1 while in IDLE.
  - Expect i_resp=0, d_resp=0 and no state change.
- Reset mid-transaction: rst=1 during D_BUSY, then mem_resp=1 two cycles later.
  - Expect mem_write=0 from the cycle after reset and d_resp never asserted.
- MEM_ARB_PERF_CNT_EN defined, 3 contended cycles plus the alternating run above.
  - Expect i_grant_cnt=2, d_grant_cnt=2 and contention_cnt equal to the count of IDLE cycles with both requests high.
